// File: rtl/split_ram_slave_if.sv
// Split request/response memory bus: initiator holds req until ack, reads return later on resp.
interface MemSplit32;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        ack;
  logic        resp;
  logic [31:0] rdata;

  modport Master (
    output req, we, addr, be, wdata,
    input  ack, resp, rdata
  );

  modport Slave (
    input  req, we, addr, be, wdata,
    output ack, resp, rdata
  );
endinterface

// File: rtl/split_ram_slave.sv
// Word RAM behind a split bus: ack after WAIT_STATES held cycles, read data RD_LATENCY cycles after ack.
// No backpressure on resp; ack never stalls for reads in flight because the read pipe is fixed-depth.
module split_ram_slave #(
  parameter int MEM_WORDS   = 1024,
  parameter int RD_LATENCY  = 1,
  parameter int WAIT_STATES = 0
) (
  input  logic      clk_i,
  input  logic      rst_i,
  MemSplit32.Slave  host
);
  localparam int AW = $clog2(MEM_WORDS);
  localparam logic [2:0] WS = 3'(WAIT_STATES);

  logic [31:0]   mem [MEM_WORDS];
  logic [2:0]    wait_cnt;
  logic          ack;
  logic          rd_ack;
  logic          wr_ack;
  logic [AW-1:0] idx;

  logic [RD_LATENCY-1:0] pipe_vld;
  logic [31:0]           pipe_dat [RD_LATENCY];

  // Byte-offset and high address bits deliberately alias onto the same word.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{host.addr[31:AW+2], host.addr[1:0]};

  assign idx    = host.addr[2 +: AW];
  assign ack    = host.req && !rst_i && (wait_cnt == WS);
  assign rd_ack = ack && !host.we;
  assign wr_ack = ack && host.we;

  assign host.ack   = ack;
  assign host.resp  = pipe_vld[RD_LATENCY-1] && !rst_i;
  assign host.rdata = host.resp ? pipe_dat[RD_LATENCY-1] : 32'h0;

  always_ff @(posedge clk_i) begin
    if (rst_i || !host.req || ack) begin
      wait_cnt <= 3'd0;
    end else begin
      wait_cnt <= wait_cnt + 3'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_ack) begin
      for (int i = 0; i < 4; i++) begin
        if (host.be[i]) begin
          mem[idx][8*i +: 8] <= host.wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pipe_vld <= '0;
    end else begin
      pipe_vld[0] <= rd_ack;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
      end
    end
  end

  // Data stages carry no reset; the valid bits alone decide what reaches the bus.
  always_ff @(posedge clk_i) begin
    if (rd_ack) begin
      pipe_dat[0] <= mem[idx];
    end
    for (int i = 1; i < RD_LATENCY; i++) begin
      pipe_dat[i] <= pipe_dat[i-1];
    end
  end
endmodule

// File: tb/tb_split_ram_slave.sv
// Directed bench: four slave instances covering default, RD_LATENCY=3, WAIT_STATES=2 and RD_LATENCY=2.
module tb_split_ram_slave;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        req_d   [4];
  logic        we_d    [4];
  logic [31:0] addr_d  [4];
  logic [3:0]  be_d    [4];
  logic [31:0] wdata_d [4];
  wire  [3:0]  ack_o;
  wire  [3:0]  resp_o;
  wire  [31:0] rdata_o [4];

  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < 4; g++) begin : gen_dut
    MemSplit32 bus ();
    assign bus.req   = req_d[g];
    assign bus.we    = we_d[g];
    assign bus.addr  = addr_d[g];
    assign bus.be    = be_d[g];
    assign bus.wdata = wdata_d[g];
    assign ack_o[g]   = bus.ack;
    assign resp_o[g]  = bus.resp;
    assign rdata_o[g] = bus.rdata;

    split_ram_slave #(
      .MEM_WORDS   (1024),
      .RD_LATENCY  ((g == 1) ? 3 : ((g == 3) ? 2 : 1)),
      .WAIT_STATES ((g == 2) ? 2 : 0)
    ) dut (
      .clk_i (clk),
      .rst_i (rst),
      .host  (bus.Slave)
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drv(input int d, input logic w, input logic [31:0] a,
                     input logic [3:0] b, input logic [31:0] wd);
    req_d[d]   = 1'b1;
    we_d[d]    = w;
    addr_d[d]  = a;
    be_d[d]    = b;
    wdata_d[d] = wd;
  endtask

  task automatic idle(input int d);
    req_d[d]   = 1'b0;
    we_d[d]    = 1'b0;
    addr_d[d]  = 32'h0;
    be_d[d]    = 4'h0;
    wdata_d[d] = 32'h0;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic exp_v;
    rst = 1'b1;
    for (int d = 0; d < 4; d++) idle(d);
    step; step;

    // Reset forces outputs low and blocks writes.
    drv(0, 1'b1, 32'h10, 4'hF, 32'h0BAD0BAD); #1;
    chk("rst_ack",   32'(ack_o[0]),  32'd0);
    chk("rst_resp",  32'(resp_o[0]), 32'd0);
    chk("rst_rdata", rdata_o[0],     32'd0);
    step;

    // Basic write/read with defaults, first cycle after reset release.
    rst = 1'b0;
    drv(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF); #1;
    chk("wr_ack", 32'(ack_o[0]), 32'd1);
    step;
    drv(0, 1'b0, 32'h10, 4'h0, 32'h0); #1;
    chk("rd_ack",    32'(ack_o[0]),  32'd1);
    chk("wr_noresp", 32'(resp_o[0]), 32'd0);
    step;
    idle(0); #1;
    chk("rd_resp", 32'(resp_o[0]), 32'd1);
    chk("rd_data", rdata_o[0],     32'hDEADBEEF);
    step;
    chk("rd_resp_end",  32'(resp_o[0]), 32'd0);
    chk("rd_rdata_end", rdata_o[0],     32'd0);

    // Partial byte-enable write, no-op write, aliased read.
    drv(0, 1'b1, 32'h20, 4'hF, 32'h11223344); step;
    drv(0, 1'b1, 32'h20, 4'h5, 32'hAABBCCDD); step;
    drv(0, 1'b0, 32'h20, 4'h0, 32'h0);        step;
    drv(0, 1'b1, 32'h20, 4'h0, 32'hFFFFFFFF); #1;
    chk("be5_resp", 32'(resp_o[0]), 32'd1);
    chk("be5_data", rdata_o[0],     32'h11BB33DD);
    step;
    drv(0, 1'b0, 32'h1023, 4'h0, 32'h0); step;
    idle(0); #1;
    chk("alias_resp", 32'(resp_o[0]), 32'd1);
    chk("alias_data", rdata_o[0],     32'h11BB33DD);
    step;
    drv(0, 1'b1, 32'h44, 4'hF, 32'h0); step;
    idle(0);

    // RD_LATENCY=3: four back-to-back reads.
    for (int i = 0; i < 4; i++) begin
      drv(1, 1'b1, 32'(4*i), 4'hF, 32'(i+1));
      step;
    end
    for (int i = 0; i < 8; i++) begin
      if (i < 4) drv(1, 1'b0, 32'(4*i), 4'h0, 32'h0);
      else       idle(1);
      #1;
      exp_v = (i >= 3) && (i <= 6);
      chk($sformatf("lat3_resp%0d", i), 32'(resp_o[1]), 32'(exp_v));
      chk($sformatf("lat3_data%0d", i), rdata_o[1], exp_v ? 32'(i-2) : 32'd0);
      step;
    end

    // WAIT_STATES=2: held request, fields changed before ack.
    drv(2, 1'b1, 32'h0, 4'hF, 32'hBAD); #1;
    chk("ws_c0", 32'(ack_o[2]), 32'd0);
    step; #1;
    chk("ws_c1", 32'(ack_o[2]), 32'd0);
    step;
    drv(2, 1'b1, 32'h0, 4'hF, 32'h7); #1;
    chk("ws_c2", 32'(ack_o[2]), 32'd1);
    step;
    idle(2); #1;
    chk("ws_c3", 32'(ack_o[2]), 32'd0);
    step;
    // Dropping req restarts the count.
    drv(2, 1'b0, 32'h0, 4'h0, 32'h0); #1;
    chk("ws_d0", 32'(ack_o[2]), 32'd0);
    step;
    idle(2); #1;
    chk("ws_d1", 32'(ack_o[2]), 32'd0);
    step;
    drv(2, 1'b0, 32'h0, 4'h0, 32'h0); #1;
    chk("ws_re0", 32'(ack_o[2]), 32'd0);
    step; #1;
    chk("ws_re1", 32'(ack_o[2]), 32'd0);
    step; #1;
    chk("ws_re2", 32'(ack_o[2]), 32'd1);
    step;
    idle(2); #1;
    chk("ws_resp", 32'(resp_o[2]), 32'd1);
    chk("ws_data", rdata_o[2],     32'h7);
    step;

    // RD_LATENCY=2: read is not affected by a later write.
    drv(3, 1'b1, 32'h8, 4'hF, 32'h5); step;
    drv(3, 1'b0, 32'h8, 4'h0, 32'h0); #1;
    chk("ord_ack", 32'(ack_o[3]), 32'd1);
    step;
    drv(3, 1'b1, 32'h8, 4'hF, 32'h9); #1;
    chk("ord_resp0", 32'(resp_o[3]), 32'd0);
    step;
    drv(3, 1'b0, 32'h8, 4'h0, 32'h0); #1;
    chk("ord_resp1", 32'(resp_o[3]), 32'd1);
    chk("ord_data1", rdata_o[3],     32'h5);
    step;
    idle(3); #1;
    chk("ord_resp2", 32'(resp_o[3]), 32'd0);
    step; #1;
    chk("ord_resp3", 32'(resp_o[3]), 32'd1);
    chk("ord_data3", rdata_o[3],     32'h9);
    step;

    // Reset mid-flight discards the read; write during reset is dropped.
    drv(3, 1'b0, 32'h8, 4'h0, 32'h0); #1;
    chk("fl_ack", 32'(ack_o[3]), 32'd1);
    step;
    idle(3);
    rst = 1'b1;
    drv(0, 1'b1, 32'h44, 4'hF, 32'hFFFFFFFF); #1;
    chk("fl_rst_ack0", 32'(ack_o[0]),  32'd0);
    chk("fl_rst_resp", 32'(resp_o[3]), 32'd0);
    step;
    rst = 1'b0;
    idle(0); #1;
    chk("fl_drop0", 32'(resp_o[3]), 32'd0);
    step; #1;
    chk("fl_drop1", 32'(resp_o[3]), 32'd0);
    step;
    drv(3, 1'b0, 32'h8, 4'h0, 32'h0); #1;
    chk("fl_rd_ack", 32'(ack_o[3]), 32'd1);
    step;
    idle(3);
    drv(0, 1'b0, 32'h44, 4'h0, 32'h0); #1;
    chk("fl_rd_wait", 32'(resp_o[3]), 32'd0);
    step;
    idle(0); #1;
    chk("fl_rd_resp",  32'(resp_o[3]), 32'd1);
    chk("fl_rd_data",  rdata_o[3],     32'h9);
    chk("rstwr_resp",  32'(resp_o[0]), 32'd1);
    chk("rstwr_data",  rdata_o[0],     32'h0);
    step;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
